// File: rtl/inv_key_sched.sv
// Iterative inverse AES-128 key schedule.
// Loads the round-10 key and walks backward one round per accepted transfer,
// emitting round keys 10, 9, ..., 0. A single SubWord (4 S-boxes) is shared by
// every step, so no table of eleven round keys is needed.

// Forward AES S-box, one byte lane.
module inv_key_sched_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    // Row 0 first; entry x lives at bit offset 8*(255-x) == 8*(~x).
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Pure table lookup.
    assign o_byte = SBOX[{~i_byte, 3'b000} +: 8];
endmodule

module inv_key_sched #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_last,
    output logic [127:0] key_out,
    output logic [3:0]   key_rnd,
    output logic         key_valid,
    input  logic         key_ready,
    output logic         busy,
    output logic         done
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [127:0]   r_key;
    logic [3:0]     r_rnd;
    logic           w_load;
    logic           w_xfer;
    logic [31:0]    w_p0, w_p1, w_p2, w_p3;
    logic [31:0]    w_rot, w_sub;
    logic [7:0]     w_rcon;
    logic [127:0]   w_inv;

    // key_valid and busy coincide: both are exactly "sequence in flight".
    assign w_xfer    = (r_state == S_RUN) && key_ready;
    assign key_valid = (r_state == S_RUN);
    assign busy      = (r_state == S_RUN);
    assign done      = w_xfer && (r_rnd == 4'd0);
    assign key_out   = r_key;
    assign key_rnd   = r_rnd;

    // Undo one forward expansion step: recover w3..w1 by pairwise XOR, then w0
    // from the new w3 through RotWord/SubWord/Rcon.
    assign w_p3  = r_key[31:0]  ^ r_key[63:32];
    assign w_p2  = r_key[63:32] ^ r_key[95:64];
    assign w_p1  = r_key[95:64] ^ r_key[127:96];
    assign w_rot = {w_p3[23:0], w_p3[31:24]};
    assign w_p0  = r_key[127:96] ^ w_sub ^ {w_rcon, 24'h0};
    assign w_inv = {w_p0, w_p1, w_p2, w_p3};

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_sbox
            inv_key_sched_sbox u_sbox (
                .i_byte (w_rot[8*g +: 8]),
                .o_byte (w_sub[8*g +: 8])
            );
        end
    endgenerate

    // Round constant for the round being undone; round 0 never steps.
    always_comb begin
        w_rcon = 8'h00;
        case (r_rnd)
            4'd1:    w_rcon = 8'h01;
            4'd2:    w_rcon = 8'h02;
            4'd3:    w_rcon = 8'h04;
            4'd4:    w_rcon = 8'h08;
            4'd5:    w_rcon = 8'h10;
            4'd6:    w_rcon = 8'h20;
            4'd7:    w_rcon = 8'h40;
            4'd8:    w_rcon = 8'h80;
            4'd9:    w_rcon = 8'h1b;
            4'd10:   w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next state: start only matters in IDLE; round-0 transfer ends the run.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: if (start) begin
                w_state_nxt = S_RUN;
                w_load      = 1'b1;
            end
            S_RUN: if (w_xfer && (r_rnd == 4'd0)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Key/round registers move only on a load or a non-final transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key <= '0;
            r_rnd <= '0;
        end else if (w_load) begin
            r_key <= key_last;
            r_rnd <= 4'(NR);
        end else if (w_xfer && (r_rnd != 4'd0)) begin
            r_key <= w_inv;
            r_rnd <= r_rnd - 4'd1;
        end
    end
endmodule

// File: tb/tb_inv_key_sched.sv
// Directed bench for inv_key_sched: FIPS-197 vector table, backpressure,
// forward-model round trips, start-while-busy, reset mid-run, all-zero key.
module tb_inv_key_sched;
    logic         clk = 1'b0;
    logic         rst, start, key_ready;
    logic [127:0] key_last, key_out;
    logic [3:0]   key_rnd;
    logic         key_valid, busy, done;
    int           n_chk = 0;
    int           n_err = 0;

    localparam logic [127:0] FIPS0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    inv_key_sched #(.NR(10)) dut (
        .clk(clk), .rst(rst), .start(start), .key_last(key_last),
        .key_out(key_out), .key_rnd(key_rnd), .key_valid(key_valid),
        .key_ready(key_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    logic [7:0]   rcon_t [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [127:0] fwd [0:10];

    function automatic logic [7:0] sb(input logic [7:0] x);
        int idx;
        idx = 8 * (255 - int'(x));
        return SBOX[idx +: 8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    // Forward AES-128 key expansion reference; fills fwd[0..10].
    task automatic expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_t[i/4], 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) fwd[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        int           cyc;
        logic [3:0]   rnd;
        logic [127:0] key;
        logic         chk_key;
        logic         valid;
        logic         bsy;
        logic         dn;
    } vec_t;

    // Full sequence against fwd[]; bp toggles key_ready, poke_rnd selects the
    // round at which a stray start (or reset) is injected. Called and returns
    // at posedge+1.
    task automatic run_seq(input logic [127:0] klast, input bit bp,
                           input int poke_rnd, input bit poke_rst);
        int  e;
        bit  fin, poked, in_rst;
        e = 10; fin = 0; poked = 0; in_rst = 0;
        start = 1'b1; key_last = klast;
        @(posedge clk); #1;
        start = 1'b0; key_last = ~klast;
        for (int c = 0; c < 200; c++) begin
            key_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!poked && e == poke_rnd) begin
                poked = 1;
                if (poke_rst) begin rst = 1'b1; in_rst = 1; end
                else begin start = 1'b1; key_last = klast ^ 128'h1; end
            end
            @(negedge clk);
            chk($sformatf("valid r%0d", e), 128'(key_valid), 128'(1));
            chk($sformatf("busy r%0d", e), 128'(busy), 128'(1));
            chk($sformatf("rnd r%0d", e), 128'(key_rnd), 128'(e));
            chk($sformatf("key r%0d", e), key_out, fwd[e]);
            chk($sformatf("done r%0d", e), 128'(done), 128'(key_ready && e == 0));
            if (in_rst) begin
                @(posedge clk); #1;
                chk("rst valid", 128'(key_valid), 128'(0));
                chk("rst busy", 128'(busy), 128'(0));
                chk("rst key", key_out, 128'(0));
                chk("rst rnd", 128'(key_rnd), 128'(0));
                chk("rst done", 128'(done), 128'(0));
                rst = 1'b0; start = 1'b0;
                return;
            end
            if (key_ready) begin
                if (e == 0) begin fin = 1; break; end
                e--;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (!fin) begin
            n_chk++; n_err++;
            $display("FAIL timeout: sequence stuck at round %0d", e);
        end
        @(posedge clk); #1;
        chk("end valid", 128'(key_valid), 128'(0));
        chk("end busy", 128'(busy), 128'(0));
    endtask

    initial begin
        vec_t   tab [5];
        int     idx;
        logic [127:0] k;

        tab[0] = '{1,  4'd10, FIPS10, 1'b1, 1'b1, 1'b1, 1'b0};
        tab[1] = '{2,  4'd9,  128'hac7766f319fadc2128d12941575c006e, 1'b1, 1'b1, 1'b1, 1'b0};
        tab[2] = '{10, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605, 1'b1, 1'b1, 1'b1, 1'b0};
        tab[3] = '{11, 4'd0,  FIPS0, 1'b1, 1'b1, 1'b1, 1'b1};
        tab[4] = '{12, 4'd0,  128'h0, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; key_ready = 1'b0; key_last = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid", 128'(key_valid), 128'(0));
        chk("reset busy", 128'(busy), 128'(0));
        chk("reset done", 128'(done), 128'(0));
        chk("reset key", key_out, 128'(0));
        chk("reset rnd", 128'(key_rnd), 128'(0));
        rst = 1'b0;

        // FIPS-197 vector, key_ready held high, cycle-accurate table.
        key_ready = 1'b1; start = 1'b1; key_last = FIPS10;
        idx = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (idx < 5 && tab[idx].cyc == c) begin
                chk($sformatf("fips c%0d valid", c), 128'(key_valid), 128'(tab[idx].valid));
                chk($sformatf("fips c%0d busy", c), 128'(busy), 128'(tab[idx].bsy));
                chk($sformatf("fips c%0d done", c), 128'(done), 128'(tab[idx].dn));
                if (tab[idx].chk_key) begin
                    chk($sformatf("fips c%0d rnd", c), 128'(key_rnd), 128'(tab[idx].rnd));
                    chk($sformatf("fips c%0d key", c), key_out, tab[idx].key);
                end
                idx++;
            end
        end

        expand(FIPS0);
        run_seq(FIPS10, 1'b1, -1, 1'b0);       // backpressure
        run_seq(FIPS10, 1'b0, 5, 1'b0);        // stray start at round 5
        k = {$urandom, $urandom, $urandom, $urandom};
        expand(k);
        run_seq(fwd[10], 1'b0, -1, 1'b0);      // starts the cycle after done
        for (int i = 0; i < 3; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            expand(k);
            run_seq(fwd[10], 1'(i), -1, 1'b0);
            chk($sformatf("roundtrip %0d key0", i), fwd[0], k);
        end
        expand(FIPS0);
        run_seq(FIPS10, 1'b0, 4, 1'b1);        // reset mid-run
        run_seq(FIPS10, 1'b0, -1, 1'b0);       // normal run afterwards

        // All-zero round-10 key: round 9 = {63636363^36000000, 0, 0, 0}.
        key_ready = 1'b1; start = 1'b1; key_last = '0;
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            chk($sformatf("zero c%0d valid", c), 128'(key_valid), 128'(1));
            chk($sformatf("zero c%0d rnd", c), 128'(key_rnd), 128'(11 - c));
            chk($sformatf("zero c%0d no-x", c), 128'($isunknown(key_out)), 128'(0));
            chk($sformatf("zero c%0d done", c), 128'(done), 128'(c == 11));
            if (c == 1) chk("zero r10 key", key_out, 128'h0);
            if (c == 2) chk("zero r9 key", key_out, 128'h55636363_00000000_00000000_00000000);
        end
        @(posedge clk); #1;
        chk("zero end valid", 128'(key_valid), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/inv_key_sched.md
Name: inv_key_sched

Overview:
- Iterative inverse AES-128 key schedule, the reverse direction of the forward round-key generator.
- Loads the round-10 key once, then walks backward one round per accepted transfer, producing round keys 10, 9, …, 0 in order.
- Feeds the decryption datapath; with one S-box word (4 S-boxes) it regenerates round keys on the fly instead of storing all eleven.

Parameters:
- NR, 10, number of AES rounds; fixed at 10 for AES-128, other values unsupported.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle request to begin a sequence; sampled only in IDLE.
- key_last  input  128  round-10 key, sampled on the start cycle; key_last[127:96] = w0.
- key_out  output  128  current round key, same word order.
- key_rnd  output  4  round index of key_out (10 down to 0).
- key_valid  output  1  key_out/key_rnd valid.
- key_ready  input  1  consumer accepts key_out when key_valid && key_ready.
- busy  output  1  high from the cycle after start until the round-0 key is accepted.
- done  output  1  one-cycle pulse, asserted in the cycle the round-0 transfer completes.

Behaviour:
- Reset, with rst=1 at a clock edge: state=IDLE, key_out=0, key_rnd=0, key_valid=0, busy=0, done=0.
- Reset mid-sequence aborts immediately; no further keys are emitted.
- States:
  - IDLE: if start=1, register key_out=key_last and key_rnd=10, set key_valid=1 and busy=1, go to RUN. First key is visible 1 cycle after start.
  - RUN: on transfer (key_valid && key_ready):
    - if key_rnd≠0: key_out←inv(key_out, key_rnd), key_rnd←key_rnd−1, key_valid stays 1.
    - if key_rnd=0: key_valid←0, busy←0, go to IDLE. done is combinationally asserted in that same cycle (key_valid && key_ready && key_rnd==0).
  - Without a transfer, key_out, key_rnd and key_valid hold stable.
  - start is ignored outside IDLE.
- inv(K, r), where K={w0,w1,w2,w3} and each w is 32 bits:
  - p3 = w3^w2
  - p2 = w2^w1
  - p1 = w1^w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {Rcon[r],24'h0}
  - result {p0,p1,p2,p3}.
  - RotWord({a,b,c,d}) = {b,c,d,a}. SubWord applies the forward AES S-box per byte.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36. Rcon[0] is never used.
- Throughput: with key_ready held at 1, one key per cycle. Start to done is exactly 11 cycles; keys appear on cycles 1–11 after start, done on cycle 11.
- Back-to-back sequences: start in the cycle right after done returns to IDLE is accepted, so a new sequence begins with zero dead cycles beyond IDLE.
- key_ready while key_valid=0 has no effect.
- key_rnd never wraps below 0.
- All datapath registers update only on a transfer or load; there is no free-running logic.

Test Plan:
- FIPS-197 key: key_last=d014f9a8c9ee2589e13f0cc8b6630ca6, pulse start, key_ready=1.
  - Cycle 1 must show key_rnd=10 with key_out=key_last.
  - Cycle 2 must show key_rnd=9, key_out=ac7766f319fadc2128d12941575c006e.
  - Cycle 10 must show key_rnd=1, key_out=a0fafe1788542cb123a339392a6c7605.
  - Cycle 11 must show key_rnd=0, key_out=2b7e151628aed2a6abf7158809cf4f3c, with done=1.
  - Cycle 12 must show key_valid=0, busy=0.
- Backpressure: same vector with key_ready toggled pseudo-randomly → identical key sequence; key_out stable whenever key_valid && !key_ready; done only on the round-0 transfer.
- Round trip: for random 128-bit keys, expand forward with the reference gen model to round 10, then run this block → the round-0 output equals the original key, and every intermediate key matches the forward schedule.
- start while busy: pulse start with a different key_last at key_rnd=5 → ignored, sequence continues unchanged. Then start in the cycle after done → new sequence loads, key_rnd=10 the next cycle.
- Reset mid-run: assert rst at key_rnd=4 → next cycle key_valid=0, busy=0, key_out=0, key_rnd=0, done=0. A subsequent start works normally.
- All-zero key_last=0 → 11 valid keys with no X. Round 9 key must equal the value computed by the bench model with Rcon=36.
